// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with halt FSM and optional return-address stack
// Define PC_UNIT_RAS_EN to build the return-address stack; otherwise call acts as jump and ret is ignored.
module pc_unit #(
    parameter int              WIDTH     = 16,
    parameter int              STEP      = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             jump_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             halted,
    output logic             wrap,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    typedef enum logic {S_RUN, S_HALT} state_t;
    typedef enum logic [2:0] {
        OP_HOLD, OP_SEQ, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET, OP_RET_EMPTY
    } op_t;

    state_t           state_q, state_d;
    op_t              op;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] seq_pc;
    logic             seq_carry;
    logic             wrap_d;
    logic [WIDTH-1:0] ras_top;

    assign {seq_carry, seq_pc} = {1'b0, pc} + (WIDTH+1)'(STEP);

    // Priority decode: only one operation is ever chosen, so discarded requests have no side effects.
    always_comb begin
        state_d = state_q;
        op      = OP_HOLD;
        if (state_q == S_RUN && !stall) begin
            if (halt)
                state_d = S_HALT;
            else if (RAS_EN && ret_en)
                op = ras_empty ? OP_RET_EMPTY : OP_RET;
            else if (call_en)
                op = OP_CALL;
            else if (jump_en)
                op = OP_JUMP;
            else if (branch_en)
                op = OP_BRANCH;
            else
                op = OP_SEQ;
        end
    end

    always_comb begin
        pc_d = pc;
        case (op)
            OP_SEQ, OP_RET_EMPTY: pc_d = seq_pc;
            OP_BRANCH:            pc_d = pc + branch_off;
            OP_JUMP, OP_CALL:     pc_d = jump_target;
            OP_RET:               pc_d = ras_top;
            default:              pc_d = pc;
        endcase
    end

    always_comb begin
        wrap_d = 1'b0;
        if (state_q == S_HALT)
            wrap_d = wrap;
        else if (op == OP_SEQ || op == OP_RET_EMPTY)
            wrap_d = seq_carry;
    end

    assign pc_next = reset ? RESET_VEC : pc_d;
    assign halted  = (state_q == S_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RUN;
            pc      <= RESET_VEC;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            wrap    <= wrap_d;
        end
    end

`ifdef PC_UNIT_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_wp;
    logic [PW-1:0]    ras_rp;
    logic [PW:0]      ras_cnt;

    // Circular buffer: a push when full lands on the oldest slot, so the newest entries survive.
    assign ras_rp    = ras_wp - PW'(1);
    assign ras_top   = ras_mem[ras_rp];
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == (PW+1)'(RAS_DEPTH));

    always_ff @(posedge clock) begin
        if (!reset && op == OP_CALL)
            ras_mem[ras_wp] <= seq_pc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
            ras_err <= 1'b0;
        end else begin
            if (state_q == S_RUN)
                ras_err <= (op == OP_RET_EMPTY) || (op == OP_CALL && ras_full);
            if (op == OP_CALL) begin
                ras_wp <= ras_wp + PW'(1);
                if (!ras_full)
                    ras_cnt <= ras_cnt + (PW+1)'(1);
            end else if (op == OP_RET) begin
                ras_wp  <= ras_rp;
                ras_cnt <= ras_cnt - (PW+1)'(1);
            end
        end
    end
`else
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector bench for pc_unit (default parameters)
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, stall, halt, branch_en, jump_en, call_en, ret_en;
    logic [15:0] branch_off, jump_target;
    logic [15:0] pc, pc_next;
    logic        halted, wrap, ras_empty, ras_full, ras_err;

    int nvec = 0;
    int nerr = 0;

    pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .halt(halt),
        .branch_en(branch_en), .branch_off(branch_off), .jump_en(jump_en),
        .call_en(call_en), .ret_en(ret_en), .jump_target(jump_target),
        .pc(pc), .pc_next(pc_next), .halted(halted), .wrap(wrap),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, stl, hlt, br;
        logic [15:0] off;
        logic        jmp;
        logic [15:0] tgt;
        logic [15:0] epc;
        logic        ewrap, ehalt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stl, logic hlt, logic br, logic [15:0] off,
                                logic jmp, logic [15:0] tgt, logic [15:0] epc, logic ew, logic eh);
        vec_t v;
        v.rst = rst; v.stl = stl; v.hlt = hlt; v.br = br; v.off = off;
        v.jmp = jmp; v.tgt = tgt; v.epc = epc; v.ewrap = ew; v.ehalt = eh;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic h, input logic br,
                         input logic [15:0] off, input logic j, input logic c, input logic rt,
                         input logic [15:0] tgt);
        reset = r; stall = st; halt = h; branch_en = br; branch_off = off;
        jump_en = j; call_en = c; ret_en = rt; jump_target = tgt;
    endtask

    task automatic step(input string nm, input logic [15:0] epc, input logic ew, input logic eh);
        #1;
        chk({nm, ".pc_next"}, pc_next, epc);
        @(posedge clock);
        #1;
        chk({nm, ".pc"}, pc, epc);
        chk({nm, ".wrap"}, {15'd0, wrap}, {15'd0, ew});
        chk({nm, ".halted"}, {15'd0, halted}, {15'd0, eh});
    endtask

    task automatic chk_ras(input string nm, input logic e, input logic f, input logic er);
        chk({nm, ".ras_empty"}, {15'd0, ras_empty}, {15'd0, e});
        chk({nm, ".ras_full"}, {15'd0, ras_full}, {15'd0, f});
        chk({nm, ".ras_err"}, {15'd0, ras_err}, {15'd0, er});
    endtask

    initial begin
        drive(1, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        //              rst stl hlt br off       jmp tgt       pc        w  h
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0006, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0008, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h000A, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFC, 16'hFFFC, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0002, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0010, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'hFFF8, 0, 16'h0000, 16'h0008, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0010, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'hFFF8, 1, 16'h0100, 16'h0100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h00F0, 0, 16'h0000, 16'h01F0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFF0, 16'hFFF0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0020, 0, 16'h0000, 16'h0010, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h5555, 16'h0010, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0010, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFE, 16'hFFFE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0020, 16'h0020, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h0300, 16'h0020, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].hlt, vecs[i].br, vecs[i].off,
                  vecs[i].jmp, 1'b0, 1'b0, vecs[i].tgt);
            step($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ewrap, vecs[i].ehalt);
            chk_ras($sformatf("vec%0d", i), 1'b1, 1'b0, 1'b0);
        end

        // HALT is sticky: every control input is ignored until reset
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 16'h0040, 1, 1, 1, 16'h0300);
            step($sformatf("halt%0d", i), 16'h0020, 0, 1);
        end
        drive(1, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0300);
        step("halt_rst", 16'h0000, 0, 0);
        drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        step("post_halt", 16'h0002, 0, 0);

        // stall alongside call for three cycles, then the call proceeds
        drive(0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0080);
        step("st_jmp", 16'h0080, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 16'h0, 0, 1, 0, 16'h0700);
            step($sformatf("st_call%0d", i), 16'h0080, 0, 0);
            chk_ras($sformatf("st_call%0d", i), 1'b1, 1'b0, 1'b0);
        end
        drive(0, 0, 0, 0, 16'h0, 0, 1, 0, 16'h0700);
        step("call_go", 16'h0700, 0, 0);
        chk_ras("call_go", !RAS, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0);
        step("call_ret", RAS ? 16'h0082 : 16'h0702, 0, 0);
        chk_ras("call_ret", 1'b1, 1'b0, 1'b0);

`ifdef PC_UNIT_RAS_EN
        drive(1, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        step("r_rst", 16'h0000, 0, 0);
        drive(0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0040);
        step("r_jmp", 16'h0040, 0, 0);
        drive(0, 0, 0, 0, 16'h0, 1, 1, 0, 16'h0200);
        step("r_call", 16'h0200, 0, 0);
        chk_ras("r_call", 1'b0, 1'b0, 1'b0);
        drive(0, 0, 0, 1, 16'h0010, 1, 1, 1, 16'h0900);
        step("r_ret", 16'h0042, 0, 0);
        chk_ras("r_ret", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 16'h0, 0, 1, 0, 16'(i * 16'h1000));
            step($sformatf("nest%0d", i), 16'(i * 16'h1000), 0, 0);
            chk_ras($sformatf("nest%0d", i), 1'b0, i >= 4, i == 5);
        end
        for (int i = 4; i >= 1; i--) begin
            drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0);
            step($sformatf("unwind%0d", i), 16'(i * 16'h1000 + 2), 0, 0);
            chk_ras($sformatf("unwind%0d", i), i == 1, 1'b0, 1'b0);
        end
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 16'h0);
        step("ret_empty", 16'h1004, 0, 0);
        chk_ras("ret_empty", 1'b1, 1'b0, 1'b1);
        drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        step("after_err", 16'h1006, 0, 0);
        chk_ras("after_err", 1'b1, 1'b0, 1'b0);
`else
        drive(0, 0, 0, 0, 16'h0, 1, 1, 0, 16'h0200);
        step("n_call", 16'h0200, 0, 0);
        chk_ras("n_call", 1'b1, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 1, 0, 1, 16'h0400);
        step("n_retjmp", 16'h0400, 0, 0);
        drive(0, 0, 0, 1, 16'h0010, 0, 0, 1, 16'h0);
        step("n_retbr", 16'h0410, 0, 0);
        chk_ras("n_retbr", 1'b1, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16, PC and address width in bits.
REQ-002 Parameter STEP, default 2, sequential increment in bytes.
REQ-003 Parameter RESET_VEC, default 0, PC value after reset.
REQ-004 Parameter RAS_DEPTH, default 4, return-address stack entries (power of two, >=2).
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold PC and stack for this cycle.
REQ-008 halt  in  1  request transition to HALT state.
REQ-009 branch_en  in  1  PC-relative branch request.
REQ-010 branch_off  in  WIDTH  two's-complement branch offset.
REQ-011 jump_en  in  1  absolute jump request.
REQ-012 call_en  in  1  call request: push return address, jump to jump_target.
REQ-013 ret_en  in  1  return request: pop stack into PC.
REQ-014 jump_target  in  WIDTH  absolute target for jump and call.
REQ-015 pc  out  WIDTH  current registered PC.
REQ-016 pc_next  out  WIDTH  combinational value PC takes at the next edge.
REQ-017 halted  out  1  high while in HALT state.
REQ-018 wrap  out  1  registered; high for one cycle after an update that carried out of WIDTH bits.
REQ-019 ras_empty  out  1  stack holds no entries.
REQ-020 ras_full  out  1  stack holds RAS_DEPTH entries.
REQ-021 ras_err  out  1  registered; one-cycle pulse on push-when-full or pop-when-empty.

Function
REQ-022 Two-state FSM: RUN, HALT; HALT exits only via reset.
REQ-023 RUN with halt=1 and stall=0: next state HALT, PC held; halt ignored while stall=1.
REQ-024 In HALT all control inputs are ignored, PC, stack, flags held; pc_next=pc.
REQ-025 Next-PC priority in RUN: stall (hold) > ret_en > call_en > jump_en > branch_en > pc+STEP.
REQ-026 Increment: pc+STEP modulo 2^WIDTH; carry-out sets wrap next cycle.
REQ-027 Branch: pc+branch_off modulo 2^WIDTH; wrap not asserted for branches.
REQ-028 Jump: PC <= jump_target; wrap low.
REQ-029 Call: push pc+STEP (modulo 2^WIDTH), PC <= jump_target.
REQ-030 Push when full: entry overwrites oldest (circular), depth stays RAS_DEPTH, ras_err pulses.
REQ-031 Ret with non-empty stack: PC <= top entry, depth decrements.
REQ-032 Ret when empty: PC <= pc+STEP, stack unchanged, ras_err pulses.
REQ-033 Stall holds PC, stack, FSM; wrap and ras_err are low in the cycle after a stall.
REQ-034 Lower-priority requests coincident with a higher one are discarded, no side effects.

Reset
REQ-035 reset=1 at an edge: pc=RESET_VEC, state RUN, stack depth 0, ras_empty=1, ras_full=0, wrap=0, ras_err=0, halted=0.
REQ-036 Reset overrides every other input, including mid-call and in HALT; stack contents are discarded.
REQ-037 While reset is high, pc_next=RESET_VEC.

Configuration
REQ-038 Macro PC_UNIT_RAS_EN defined: stack present as specified.
REQ-039 Macro absent: no stack storage; call_en behaves as jump_en; ret_en ignored (falls to lower priority); ras_empty=1, ras_full=0, ras_err=0 constant.

Verification
REQ-040 Reset, then 5 free-run cycles, STEP=2 -> pc 0,2,4,6,8,10; wrap=0.
REQ-041 pc=16'hFFFE, no request -> pc=16'h0000, wrap=1 for one cycle, then 0 at pc=2.
REQ-042 pc=16'h0010, branch_off=16'hFFF8 -> pc=16'h0008; with jump_en=1 and jump_target=16'h0100 in the same cycle -> pc=16'h0100.
REQ-043 RAS_EN: call to 0x0200 from pc 0x0040, ret -> pc 0x0042, ras_empty=1; 5 nested calls at depth 4 -> ras_err pulse, 4 rets return the 4 newest addresses, 5th ret -> ras_err, pc+2.
REQ-044 halt at pc=0x0020 -> halted=1, pc frozen at 0x0020 for 10 cycles despite jump_en; reset -> pc=0, halted=0.
REQ-045 stall=1 for 3 cycles alongside call_en -> pc and stack unchanged; call takes effect on the first cycle after stall falls.
